// File: rtl/memory_stage.sv
// memory_stage -- memory-access stage of the RV64 five-stage pipeline.
//
// Sits between execute and write-back. Issues load/store requests to data
// memory over a req/ready + rvalid handshake, aligns and extends load data,
// builds store byte-enables and holds the MEM/WB pipeline register.
//
// Optional feature macro: MISALIGN_EXC_EN
//   defined   : misaligned accesses issue no request and complete at once,
//               registering an exception (cause 4 load / 6 store, ecall=1).
//   undefined : the byte offset is forced to natural alignment and the
//               access proceeds normally; o_cause passes i_cause.
//
// Ports:
//   i_clk, i_arst            clock, async active-high reset
//   i_* (execute side)       instruction fields from EX/MEM
//   o_mem_req/we/addr/wdata/be, i_mem_ready    request channel
//   i_mem_rvalid/rdata       load response channel
//   o_stall_mem              stall to hazard unit while access outstanding
//   o_* (write-back side)    registered MEM/WB outputs
module memory_stage #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
   input  logic [ADDR_WIDTH-1:0] i_pc_target,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   input  logic [DATA_WIDTH-1:0] i_imm_ext,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic [2:0]            i_result_src,
   input  logic [2:0]            i_func3,
   input  logic                  i_mem_re,
   input  logic                  i_mem_we,
   input  logic                  i_reg_we,
   input  logic                  i_ecall_instr,
   input  logic [3:0]            i_cause,
   input  logic                  i_a0_reg_lsb,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic [7:0]            o_mem_be,
   input  logic                  i_mem_ready,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_stall_mem,
   output logic                  o_valid,
   output logic [ADDR_WIDTH-1:0] o_pc_plus4,
   output logic [ADDR_WIDTH-1:0] o_pc_target,
   output logic [DATA_WIDTH-1:0] o_alu_result,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [DATA_WIDTH-1:0] o_imm_ext,
   output logic [2:0]            o_result_src,
   output logic                  o_ecall_instr,
   output logic [3:0]            o_cause,
   output logic                  o_a0_reg_lsb,
   output logic                  o_reg_we
);

   typedef enum logic {IDLE, WAIT_RESP} state_t;

   state_t state_q, state_d;

   logic                  mem_op;
   logic                  is_store;
   logic [2:0]            off_raw;
   logic [2:0]            size_mask;
   logic [2:0]            off;
   logic                  misalign;
   logic                  req;
   logic                  done;
   logic                  load_done;
   logic [7:0]            be;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_data;

   // When both re and we are set the access is a store.
   assign mem_op   = i_valid & (i_mem_re | i_mem_we);
   assign is_store = i_mem_we;
   assign off_raw  = i_alu_result[2:0];

   // Low offset bits that must be zero for a naturally aligned access.
   always_comb begin
      size_mask = 3'd0;
      case (i_func3[1:0])
         2'd0:    size_mask = 3'd0;
         2'd1:    size_mask = 3'd1;
         2'd2:    size_mask = 3'd3;
         default: size_mask = 3'd7;
      endcase
   end

`ifdef MISALIGN_EXC_EN
   assign misalign = mem_op & (|(off_raw & size_mask));
   assign off      = off_raw;
`else
   assign misalign = 1'b0;
   assign off      = off_raw & ~size_mask;
`endif

   // Next-state / handshake decode.
   always_comb begin
      state_d   = state_q;
      req       = 1'b0;
      done      = 1'b0;
      load_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (misalign) begin
                  done = 1'b1;
               end else begin
                  req = 1'b1;
                  if (i_mem_ready) begin
                     if (is_store) done    = 1'b1;
                     else          state_d = WAIT_RESP;
                  end
               end
            end
         end
         WAIT_RESP: begin
            if (i_mem_rvalid) begin
               done      = 1'b1;
               load_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte enables are also presented for loads; memory may ignore them.
   always_comb begin
      be = 8'h00;
      case (i_func3[1:0])
         2'd0:    be = 8'h01 << off;
         2'd1:    be = 8'h03 << off;
         2'd2:    be = 8'h0F << off;
         default: be = 8'hFF;
      endcase
   end

   assign o_mem_req   = req & ~i_arst;
   assign o_mem_we    = o_mem_req & is_store;
   assign o_mem_addr  = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
   assign o_mem_wdata = i_write_data << {off, 3'b000};
   assign o_mem_be    = o_mem_req ? be : 8'h00;
   // In WAIT_RESP the load is still presented (inputs held), so mem_op stays 1.
   assign o_stall_mem = mem_op & ~done & ~i_arst;

   // Load alignment and extension.
   assign shifted = i_mem_rdata >> {off, 3'b000};
   always_comb begin
      load_data = '0;
      case (i_func3)
         3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
         3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
         3'b011:  load_data = shifted;
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         3'b110:  load_data = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
         default: load_data = '0;
      endcase
   end

   // MEM/WB register. While stalled a bubble is loaded (valid/reg_we/ecall
   // cleared); the remaining fields simply track the held inputs.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q       <= IDLE;
         o_valid       <= 1'b0;
         o_pc_plus4    <= '0;
         o_pc_target   <= '0;
         o_alu_result  <= '0;
         o_read_data   <= '0;
         o_rd_addr     <= '0;
         o_imm_ext     <= '0;
         o_result_src  <= '0;
         o_ecall_instr <= 1'b0;
         o_cause       <= '0;
         o_a0_reg_lsb  <= 1'b0;
         o_reg_we      <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_pc_plus4   <= i_pc_plus4;
         o_pc_target  <= i_pc_target;
         o_alu_result <= i_alu_result;
         o_rd_addr    <= i_rd_addr;
         o_imm_ext    <= i_imm_ext;
         o_result_src <= i_result_src;
         o_a0_reg_lsb <= i_a0_reg_lsb;
         o_cause      <= misalign ? (is_store ? 4'd6 : 4'd4) : i_cause;
         if (load_done) o_read_data <= load_data;
         if (o_stall_mem) begin
            o_valid       <= 1'b0;
            o_reg_we      <= 1'b0;
            o_ecall_instr <= 1'b0;
         end else begin
            o_valid       <= i_valid;
            o_reg_we      <= i_reg_we & ~misalign;
            o_ecall_instr <= i_ecall_instr | misalign;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage -- randomized bench for memory_stage with a transaction-
// level reference model; directed cases pin the model with literal values.
module tb_memory_stage;

   logic        i_clk = 1'b0;
   logic        i_arst = 1'b1;
   logic        i_valid = 0, i_mem_re = 0, i_mem_we = 0, i_reg_we = 0;
   logic        i_ecall_instr = 0, i_a0_reg_lsb = 0;
   logic [63:0] i_pc_plus4 = 0, i_pc_target = 0, i_alu_result = 0;
   logic [63:0] i_write_data = 0, i_imm_ext = 0, i_mem_rdata = 0;
   logic [4:0]  i_rd_addr = 0;
   logic [2:0]  i_result_src = 0, i_func3 = 0;
   logic [3:0]  i_cause = 0;
   logic        i_mem_ready = 0, i_mem_rvalid = 0;
   logic        o_mem_req, o_mem_we, o_stall_mem, o_valid, o_ecall_instr;
   logic        o_a0_reg_lsb, o_reg_we;
   logic [63:0] o_mem_addr, o_mem_wdata, o_pc_plus4, o_pc_target;
   logic [63:0] o_alu_result, o_read_data, o_imm_ext;
   logic [7:0]  o_mem_be;
   logic [4:0]  o_rd_addr;
   logic [2:0]  o_result_src;
   logic [3:0]  o_cause;

   always #5 i_clk = ~i_clk;

   memory_stage dut (
      .i_clk(i_clk), .i_arst(i_arst), .i_valid(i_valid),
      .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
      .i_alu_result(i_alu_result), .i_write_data(i_write_data),
      .i_imm_ext(i_imm_ext), .i_rd_addr(i_rd_addr),
      .i_result_src(i_result_src), .i_func3(i_func3),
      .i_mem_re(i_mem_re), .i_mem_we(i_mem_we), .i_reg_we(i_reg_we),
      .i_ecall_instr(i_ecall_instr), .i_cause(i_cause),
      .i_a0_reg_lsb(i_a0_reg_lsb), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
      .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata), .o_stall_mem(o_stall_mem),
      .o_valid(o_valid), .o_pc_plus4(o_pc_plus4),
      .o_pc_target(o_pc_target), .o_alu_result(o_alu_result),
      .o_read_data(o_read_data), .o_rd_addr(o_rd_addr),
      .o_imm_ext(o_imm_ext), .o_result_src(o_result_src),
      .o_ecall_instr(o_ecall_instr), .o_cause(o_cause),
      .o_a0_reg_lsb(o_a0_reg_lsb), .o_reg_we(o_reg_we)
   );

   typedef struct {
      logic valid, re, we, reg_we, ecall, a0;
      logic [2:0] f3, rs;
      logic [3:0] cause;
      logic [4:0] rd;
      logic [63:0] alu, wd, imm, pc4, pct;
   } instr_t;

   typedef struct {
      logic valid, reg_we, ecall, a0;
      logic [2:0] rs;
      logic [3:0] cause;
      logic [4:0] rd;
      logic [63:0] pc4, pct, alu, rdata, imm;
   } wb_t;

   int total = 0, bad = 0;
   wb_t exp_reg, exp_nxt;
   logic reg_bubble = 0, nxt_bubble = 0;
   logic e_req = 0, e_stall = 0, e_we = 0, e_chk_wdata = 0, in_rst = 1;
   logic [63:0] e_addr = 0, e_wdata = 0;
   logic [7:0] e_be = 0;
   logic [63:0] mdl_rd = 0;
   logic chk_en = 0;
   int stall_cnt = 0, req_cnt = 0;
   logic [63:0] cap_addr = 0, cap_wdata = 0;
   logic [7:0] cap_be = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic is_mem(input instr_t t);
      return t.valid && (t.re || t.we);
   endfunction

   function automatic logic mis(input instr_t t);
`ifdef MISALIGN_EXC_EN
      return is_mem(t) && ((int'(t.alu[2:0]) % acc_size(t.f3)) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eoff(input instr_t t);
      int raw, n;
      raw = int'(t.alu[2:0]);
      n = acc_size(t.f3);
`ifdef MISALIGN_EXC_EN
      return raw;
`else
      return (raw / n) * n;
`endif
   endfunction

   function automatic logic [7:0] mbe(input instr_t t);
      logic [15:0] m;
      m = ((16'd1 << acc_size(t.f3)) - 16'd1) << eoff(t);
      return m[7:0];
   endfunction

   function automatic logic [63:0] mextract(input logic [63:0] raw, input logic [2:0] f3, input int off);
      logic [63:0] d, v;
      int nb;
      d = raw >> (8 * off);
      if (f3 == 3'b111) return 64'd0;
      nb = 8 * acc_size(f3);
      if (nb == 64) return d;
      v = d & ((64'd1 << nb) - 64'd1);
      if (!f3[2] && v[nb-1]) v = v - (64'd1 << nb);
      return v;
   endfunction

   function automatic wb_t final_wb(input instr_t t);
      wb_t w;
      logic m;
      m = mis(t);
      w.valid = t.valid; w.pc4 = t.pc4; w.pct = t.pct; w.alu = t.alu;
      w.imm = t.imm; w.rd = t.rd; w.rs = t.rs; w.a0 = t.a0;
      w.reg_we = m ? 1'b0 : t.reg_we;
      w.ecall  = m ? 1'b1 : t.ecall;
      w.cause  = m ? (t.we ? 4'd6 : 4'd4) : t.cause;
      w.rdata  = mdl_rd;
      return w;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("stall", {63'd0, o_stall_mem}, {63'd0, e_stall});
         chk("req", {63'd0, o_mem_req}, {63'd0, e_req});
         if (o_stall_mem === 1'b1) stall_cnt++;
         if (o_mem_req === 1'b1) begin
            req_cnt++;
            cap_addr = o_mem_addr; cap_be = o_mem_be; cap_wdata = o_mem_wdata;
         end
         if (e_req) begin
            chk("mem_addr", o_mem_addr, e_addr);
            chk("mem_be", {56'd0, o_mem_be}, {56'd0, e_be});
            chk("mem_we", {63'd0, o_mem_we}, {63'd0, e_we});
            if (e_chk_wdata) chk("mem_wdata", o_mem_wdata, e_wdata);
         end
         if (in_rst) chk("be_in_reset", {56'd0, o_mem_be}, 64'd0);
         chk("valid", {63'd0, o_valid}, {63'd0, exp_reg.valid});
         chk("reg_we", {63'd0, o_reg_we}, {63'd0, exp_reg.reg_we});
         chk("ecall", {63'd0, o_ecall_instr}, {63'd0, exp_reg.ecall});
         chk("read_data", o_read_data, exp_reg.rdata);
         if (!reg_bubble) begin
            chk("pc_plus4", o_pc_plus4, exp_reg.pc4);
            chk("pc_target", o_pc_target, exp_reg.pct);
            chk("alu_result", o_alu_result, exp_reg.alu);
            chk("imm_ext", o_imm_ext, exp_reg.imm);
            chk("rd_addr", {59'd0, o_rd_addr}, {59'd0, exp_reg.rd});
            chk("result_src", {61'd0, o_result_src}, {61'd0, exp_reg.rs});
            chk("cause", {60'd0, o_cause}, {60'd0, exp_reg.cause});
            chk("a0_lsb", {63'd0, o_a0_reg_lsb}, {63'd0, exp_reg.a0});
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic apply(input instr_t t);
      i_valid = t.valid; i_mem_re = t.re; i_mem_we = t.we; i_reg_we = t.reg_we;
      i_ecall_instr = t.ecall; i_a0_reg_lsb = t.a0; i_func3 = t.f3;
      i_result_src = t.rs; i_cause = t.cause; i_rd_addr = t.rd;
      i_alu_result = t.alu; i_write_data = t.wd; i_imm_ext = t.imm;
      i_pc_plus4 = t.pc4; i_pc_target = t.pct;
      e_addr = {t.alu[63:3], 3'b000};
      e_be = mbe(t);
      e_we = t.we;
      e_wdata = t.wd << (8 * eoff(t));
      e_chk_wdata = t.we;
   endtask

   // One clock: drive handshake, state expectations, cross the edge.
   task automatic step(input logic rdy, input logic rv, input logic [63:0] rdata,
                       input logic stall, input logic req, input logic bubble, input wb_t fin);
      i_mem_ready = rdy; i_mem_rvalid = rv; i_mem_rdata = rdata;
      e_stall = stall; e_req = req;
      exp_nxt = fin;
      if (bubble) begin
         exp_nxt.valid = 1'b0; exp_nxt.reg_we = 1'b0; exp_nxt.ecall = 1'b0;
      end
      nxt_bubble = bubble;
      @(posedge i_clk);
      #1;
      exp_reg = exp_nxt;
      reg_bubble = nxt_bubble;
   endtask

   task automatic run_instr(input instr_t t, input int rd_lat, input int rv_lat, input logic [63:0] resp);
      wb_t fin;
      apply(t);
      fin = final_wb(t);
      if (!is_mem(t) || mis(t)) begin
         step($urandom_range(0, 1), $urandom_range(0, 1), r64(), 0, 0, 0, fin);
      end else if (t.we) begin
         for (int c = 0; c <= rd_lat; c++)
            step(c == rd_lat, $urandom_range(0, 1), r64(), c < rd_lat, 1, c < rd_lat, fin);
      end else begin
         // rvalid noise before acceptance must be ignored
         for (int c = 0; c <= rd_lat; c++)
            step(c == rd_lat, $urandom_range(0, 1), r64(), 1, 1, 1, fin);
         for (int w = 0; w <= rv_lat; w++) begin
            if (w == rv_lat) begin
               mdl_rd = mextract(resp, t.f3, eoff(t));
               fin.rdata = mdl_rd;
               step($urandom_range(0, 1), 1, resp, 0, 0, 0, fin);
            end else begin
               step($urandom_range(0, 1), 0, r64(), 1, 0, 1, fin);
            end
         end
      end
      i_mem_ready = 0; i_mem_rvalid = 0;
   endtask

   task automatic do_reset(input int n);
      i_arst = 1; in_rst = 1;
      e_req = 0; e_stall = 0;
      mdl_rd = 0;
      exp_reg = '{default: '0};
      reg_bubble = 0;
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
      i_arst = 0; in_rst = 0;
   endtask

   function automatic instr_t base_instr();
      instr_t t;
      t.valid = 1; t.re = 0; t.we = 0; t.reg_we = 0; t.ecall = 0; t.a0 = 0;
      t.f3 = 0; t.rs = 0; t.cause = 0; t.rd = 0;
      t.alu = 0; t.wd = 0; t.imm = 0; t.pc4 = 0; t.pct = 0;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int kind;
      kind = $urandom_range(0, 9);
      t.valid = (kind == 9) ? 1'b0 : 1'b1;
      t.re = (kind < 4) || (kind == 9);
      t.we = (kind >= 4 && kind < 7) || (kind == 3 && $urandom_range(0, 1) == 1);
      t.reg_we = $urandom_range(0, 1); t.ecall = ($urandom_range(0, 7) == 0);
      t.a0 = $urandom_range(0, 1);
      t.f3 = t.we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      t.rs = 3'($urandom_range(0, 7)); t.cause = 4'($urandom_range(0, 15));
      t.rd = 5'($urandom_range(0, 31));
      t.alu = r64(); t.wd = r64(); t.imm = r64(); t.pc4 = r64(); t.pct = r64();
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t t;
      logic [63:0] rdat;
      exp_reg = '{default: '0};
      exp_nxt = '{default: '0};
      chk_en = 1;
      do_reset(3);

      // ADD: pass-through, no request or stall
      t = base_instr(); t.alu = 64'h1234; t.rd = 5; t.reg_we = 1;
      stall_cnt = 0; req_cnt = 0;
      run_instr(t, 0, 0, 0);
      chk("add_alu", o_alu_result, 64'h1234);
      chk("add_rd", {59'd0, o_rd_addr}, 64'd5);
      chk("add_valid", {63'd0, o_valid}, 64'd1);
      chk("add_nostall", stall_cnt, 0);
      chk("add_noreq", req_cnt, 0);

      // SB at 0x1003, ready same cycle
      t = base_instr(); t.we = 1; t.f3 = 3'b000; t.alu = 64'h1003; t.wd = 64'hAB;
      stall_cnt = 0;
      run_instr(t, 0, 0, 0);
      chk("sb_addr", cap_addr, 64'h1000);
      chk("sb_be", {56'd0, cap_be}, 64'h08);
      chk("sb_lane", {56'd0, cap_wdata[31:24]}, 64'hAB);
      chk("sb_nostall", stall_cnt, 0);
      chk("sb_valid", {63'd0, o_valid}, 64'd1);

      // LB at 0x2005: ready after 2, rvalid 3 cycles later
      rdat = 64'h0000_80FF_0000_0000;
      t = base_instr(); t.re = 1; t.f3 = 3'b000; t.alu = 64'h2005; t.reg_we = 1;
      stall_cnt = 0;
      run_instr(t, 2, 2, rdat);
      chk("lb_stall_cycles", stall_cnt, 5);
      chk("lb_data", o_read_data, 64'hFFFF_FFFF_FFFF_FF80);

      t.f3 = 3'b110; t.alu = 64'h2004;
      run_instr(t, 1, 0, rdat);
      chk("lwu_data", o_read_data, 64'h0000_0000_0000_80FF);
      t.f3 = 3'b010;
      run_instr(t, 0, 1, rdat);
      chk("lw_data", o_read_data, 64'h0000_0000_0000_80FF);
      t.f3 = 3'b001;
      run_instr(t, 0, 0, rdat);
      chk("lh_data", o_read_data, 64'hFFFF_FFFF_FFFF_80FF);

      // Reset while waiting for the response, then a late rvalid
      t = base_instr(); t.re = 1; t.f3 = 3'b011; t.alu = 64'h4000;
      apply(t);
      step(1, 0, 0, 1, 1, 1, final_wb(t));
      step(0, 0, 0, 1, 0, 1, final_wb(t));
      do_reset(2);
      stall_cnt = 0;
      t = base_instr(); t.valid = 0;
      run_instr(t, 0, 0, 0);
      i_mem_rvalid = 1; i_mem_rdata = 64'hDEAD_BEEF_1234_5678;
      t = base_instr();
      apply(t);
      step(0, 1, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, final_wb(t));
      i_mem_rvalid = 0;
      chk("rst_read_data", o_read_data, 64'd0);
      chk("rst_nostall", stall_cnt, 0);

      // LW at 0x3002: misaligned
      t = base_instr(); t.re = 1; t.f3 = 3'b010; t.alu = 64'h3002; t.reg_we = 1;
      req_cnt = 0;
      run_instr(t, 0, 0, 64'h1122_3344_5566_7788);
`ifdef MISALIGN_EXC_EN
      chk("mis_noreq", req_cnt, 0);
      chk("mis_cause", {60'd0, o_cause}, 64'd4);
      chk("mis_reg_we", {63'd0, o_reg_we}, 64'd0);
      chk("mis_ecall", {63'd0, o_ecall_instr}, 64'd1);
`else
      chk("mis_be", {56'd0, cap_be}, 64'h0F);
      chk("mis_addr", cap_addr, 64'h3000);
      chk("mis_data", o_read_data, 64'h0000_0000_5566_7788);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), r64());

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
